// File: rtl/test_checker_if.sv
// Observed memory-write bus seen by the checker.
// Handshake: memwrite is a per-cycle strobe that qualifies addr/wd in that same cycle; there is no ready/backpressure, the checker only observes.
interface test_checker_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          memwrite;
  logic [AW-1:0] addr;
  logic [DW-1:0] wd;

  modport master (output memwrite, addr, wd);
  modport slave  (input  memwrite, addr, wd);
endinterface

// File: rtl/test_checker.sv
// Watches a write bus and checks that a programmed sequence of (address, data)
// writes occurs in order, reporting pass, failure cause, failing index and run length.
module test_checker #(
  parameter  int AW      = 32,
  parameter  int DW      = 32,
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 100000,
  parameter  int STRICT  = 1,
  localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  test_checker_if.slave       bus,
  input  logic                cfg_we,
  input  logic [IW-1:0]       cfg_idx,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [DW-1:0]       cfg_data,
  input  logic [IW:0]         cfg_count,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [1:0]          fail_code,
  output logic [IW-1:0]       fail_idx,
  output logic [31:0]         cycles,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   count_q, count_d;
  logic [31:0]   cycles_q, cycles_d;
  logic [1:0]    code_q, code_d;
  logic [IW-1:0] fidx_q, fidx_d;

  logic [AW-1:0] exp_addr [DEPTH];
  logic [DW-1:0] exp_data [DEPTH];

  logic idx_ok, addr_hit, data_hit, last, timeout_hit;

  assign idx_ok      = ({1'b0, cfg_idx} < DEPTH_L);
  assign addr_hit    = bus.memwrite && (bus.addr == exp_addr[ptr_q]);
  assign data_hit    = (bus.wd == exp_data[ptr_q]);
  assign last        = ({1'b0, ptr_q} == (count_q - 1'b1));
  assign timeout_hit = TO_EN && (cycles_q == TO_LAST);

  // Table survives reset; it is frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (!reset && cfg_we && (state_q != S_RUN) && idx_ok) begin
      exp_addr[cfg_idx] <= cfg_addr;
      exp_data[cfg_idx] <= cfg_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    count_d  = count_q;
    cycles_d = cycles_q;
    code_d   = code_q;
    fidx_d   = fidx_q;
    unique case (state_q)
      S_RUN: begin
        if (cycles_q != '1) cycles_d = cycles_q + 32'd1;
        if (count_q == '0) begin
          state_d = S_PASS;
        end else if (addr_hit && data_hit) begin
          ptr_d = ptr_q + 1'b1;
          if (last) state_d = S_PASS;
        end else if (addr_hit) begin
          state_d = S_FAIL;
          code_d  = 2'd1;
          fidx_d  = ptr_q;
        end else if (bus.memwrite && (STRICT != 0)) begin
          state_d = S_FAIL;
          code_d  = 2'd2;
          fidx_d  = ptr_q;
        end
        // Timeout only applies when nothing else decided the run this cycle.
        if ((state_d == S_RUN) && timeout_hit) begin
          state_d = S_FAIL;
          code_d  = 2'd3;
          fidx_d  = ptr_q;
        end
      end
      default: begin
        if (start) begin
          state_d  = S_RUN;
          count_d  = cfg_count;
          ptr_d    = '0;
          cycles_d = '0;
          code_d   = '0;
          fidx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      count_q  <= '0;
      cycles_q <= '0;
      code_q   <= '0;
      fidx_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      cycles_q <= cycles_d;
      code_q   <= code_d;
      fidx_q   <= fidx_d;
      busy     <= (state_d == S_RUN);
      done     <= (state_d == S_PASS) || (state_d == S_FAIL);
      pass     <= (state_d == S_PASS);
    end
  end

  assign fail_code = code_q;
  assign fail_idx  = fidx_q;
  assign cycles    = cycles_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_test_checker.sv
// Bench for test_checker: two instances (strict with timeout 10, lenient without timeout)
// share one bus; a rule-level model predicts each run's outcome into per-instance queues.
module tb_test_checker;

  localparam int MAXT  = 64;
  localparam int RES_W = 37;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  test_checker_if #(.AW(32), .DW(32)) bus_if ();

  logic        cfg_we, start;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data;
  logic [2:0]  cfg_count;

  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [1:0]  fc0, fc1, fi0, fi1, st0, st1;
  logic [31:0] cyc0, cyc1;

  test_checker #(.AW(32), .DW(32), .DEPTH(4), .TIMEOUT(10), .STRICT(1)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus_if.slave),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_count(cfg_count), .start(start),
    .busy(busy0), .done(done0), .pass(pass0), .fail_code(fc0), .fail_idx(fi0),
    .cycles(cyc0), .dbg_state(st0));

  test_checker #(.AW(32), .DW(32), .DEPTH(4), .TIMEOUT(0), .STRICT(0)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus_if.slave),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_count(cfg_count), .start(start),
    .busy(busy1), .done(done1), .pass(pass1), .fail_code(fc1), .fail_idx(fi1),
    .cycles(cyc1), .dbg_state(st1));

  // Scoreboard: packed {pass, fail_code, fail_idx, cycles}
  logic [RES_W-1:0] exp_q0[$];
  logic [RES_W-1:0] exp_q1[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference table and per-cycle bus trace for the run being issued
  logic [31:0] m_addr [4];
  logic [31:0] m_data [4];
  bit          tr_we    [MAXT];
  logic [31:0] tr_a     [MAXT];
  logic [31:0] tr_d     [MAXT];
  bit          tr_start [MAXT];
  bit          tr_cwe   [MAXT];
  int          tr_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outcome of a run from the ordering rules: k is the number of RUN cycles already elapsed.
  function automatic logic [RES_W-1:0] model(input bit strict, input int timeout, input int cnt);
    int p = 0;
    if (cnt == 0) return {1'b1, 2'd0, 2'd0, 32'd1};
    for (int k = 0; k < MAXT; k++) begin
      if (k < tr_len && tr_we[k]) begin
        if (tr_a[k] == m_addr[p]) begin
          if (tr_d[k] != m_data[p]) return {1'b0, 2'd1, 2'(p), 32'(k + 1)};
          p++;
          if (p == cnt) return {1'b1, 2'd0, 2'd0, 32'(k + 1)};
        end else if (strict) begin
          return {1'b0, 2'd2, 2'(p), 32'(k + 1)};
        end
      end
      if (timeout != 0 && k == timeout - 1) return {1'b0, 2'd3, 2'(p), 32'(k + 1)};
    end
    return '1;
  endfunction

  task automatic compare_res(input int which, input logic [RES_W-1:0] act, input logic bsy);
    logic [RES_W-1:0] e;
    if (which == 0 && exp_q0.size() == 0 || which == 1 && exp_q1.size() == 0) begin
      check($sformatf("dut%0d_unexpected_done", which), 64'd1, 64'd0);
      return;
    end
    e = (which == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    check($sformatf("dut%0d_pass", which),      64'(act[36]),    64'(e[36]));
    check($sformatf("dut%0d_fail_code", which), 64'(act[35:34]), 64'(e[35:34]));
    check($sformatf("dut%0d_fail_idx", which),  64'(act[33:32]), 64'(e[33:32]));
    check($sformatf("dut%0d_cycles", which),    64'(act[31:0]),  64'(e[31:0]));
    check($sformatf("dut%0d_busy_low", which),  64'(bsy),        64'd0);
  endtask

  // Monitor: each rising edge of done is one finished run to score
  initial begin
    bit p0 = 1'b0;
    bit p1 = 1'b0;
    forever begin
      @(negedge clk);
      if (done0 && !p0) compare_res(0, {pass0, fc0, fi0, cyc0}, busy0);
      if (done1 && !p1) compare_res(1, {pass1, fc1, fi1, cyc1}, busy1);
      p0 = done0;
      p1 = done1;
    end
  end

  task automatic idle_inputs();
    start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    bus_if.memwrite = 1'b0; bus_if.addr = '0; bus_if.wd = '0;
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = a; cfg_data = d;
    m_addr[idx] = a; m_data[idx] = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic tr_clear();
    tr_len = 0;
  endtask

  task automatic tr_push(input bit we, input logic [31:0] a, input logic [31:0] d);
    tr_we[tr_len] = we; tr_a[tr_len] = a; tr_d[tr_len] = d;
    tr_start[tr_len] = 1'b0; tr_cwe[tr_len] = 1'b0;
    tr_len++;
  endtask

  task automatic tr_idle(input int n);
    for (int i = 0; i < n; i++) tr_push(1'b0, 32'd0, 32'd0);
  endtask

  // Start cycle optionally carries a table write; the bus write in that cycle must be ignored.
  task automatic do_run(input int cnt, input bit sc_we, input int sc_idx,
                        input logic [31:0] sc_a, input logic [31:0] sc_d);
    int w;
    @(posedge clk); #1;
    start = 1'b1; cfg_count = 3'(cnt);
    if (sc_we) begin
      cfg_we = 1'b1; cfg_idx = 2'(sc_idx); cfg_addr = sc_a; cfg_data = sc_d;
      m_addr[sc_idx] = sc_a; m_data[sc_idx] = sc_d;
    end
    bus_if.memwrite = 1'b1; bus_if.addr = m_addr[0]; bus_if.wd = ~m_data[0];
    exp_q0.push_back(model(1'b1, 10, cnt));
    exp_q1.push_back(model(1'b0, 0, cnt));
    for (int k = 0; k < tr_len; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      bus_if.memwrite = tr_we[k]; bus_if.addr = tr_a[k]; bus_if.wd = tr_d[k];
      start = tr_start[k];
      if (tr_cwe[k]) begin
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_addr = 32'd84; cfg_data = 32'd99;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    w = 0;
    while (!(done0 && done1) && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 40) check("run_completion_wait", 64'd0, 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_busy0"}, 64'(busy0), 0);  check({tag, "_busy1"}, 64'(busy1), 0);
    check({tag, "_done0"}, 64'(done0), 0);  check({tag, "_done1"}, 64'(done1), 0);
    check({tag, "_pass0"}, 64'(pass0), 0);  check({tag, "_pass1"}, 64'(pass1), 0);
    check({tag, "_code0"}, 64'(fc0), 0);    check({tag, "_code1"}, 64'(fc1), 0);
    check({tag, "_idx0"},  64'(fi0), 0);    check({tag, "_idx1"},  64'(fi1), 0);
    check({tag, "_cyc0"},  64'(cyc0), 0);   check({tag, "_cyc1"},  64'(cyc1), 0);
    check({tag, "_state0"}, 64'(st0), 0);   check({tag, "_state1"}, 64'(st1), 0);
  endtask

  initial begin
    idle_inputs();
    cfg_count = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_values("reset");

    // Single entry: match, then data mismatch
    cfg_write(0, 32'd80, 32'd144);
    tr_clear(); tr_push(1'b1, 32'd80, 32'd144);
    do_run(1, 1'b0, 0, 0, 0);
    tr_clear(); tr_push(1'b1, 32'd80, 32'd143);
    do_run(1, 1'b0, 0, 0, 0);

    // Stray address: strict fails at idx 1, lenient ignores it
    cfg_write(0, 32'd80, 32'd1);
    cfg_write(1, 32'd84, 32'd2);
    tr_clear(); tr_push(1'b1, 32'd80, 32'd1); tr_push(1'b1, 32'd88, 32'd5); tr_push(1'b1, 32'd84, 32'd2);
    do_run(2, 1'b0, 0, 0, 0);

    // Start and table write during RUN must not disturb the run or the table
    tr_clear(); tr_push(1'b1, 32'd80, 32'd1); tr_idle(1); tr_push(1'b1, 32'd84, 32'd2);
    tr_start[1] = 1'b1; tr_cwe[1] = 1'b1;
    do_run(2, 1'b0, 0, 0, 0);
    tr_clear(); tr_push(1'b1, 32'd80, 32'd1); tr_push(1'b1, 32'd84, 32'd2);
    do_run(2, 1'b0, 0, 0, 0);

    // Timeout boundary: write after, at, and as a mismatch at the last cycle
    cfg_write(0, 32'd80, 32'd144);
    tr_clear(); tr_idle(10); tr_push(1'b1, 32'd80, 32'd144);
    do_run(1, 1'b0, 0, 0, 0);
    tr_clear(); tr_idle(9); tr_push(1'b1, 32'd80, 32'd144);
    do_run(1, 1'b0, 0, 0, 0);
    tr_clear(); tr_idle(9); tr_push(1'b1, 32'd80, 32'd143);
    do_run(1, 1'b0, 0, 0, 0);

    // Table write in the start cycle is used by that run
    tr_clear(); tr_push(1'b1, 32'd200, 32'd7);
    do_run(1, 1'b1, 0, 32'd200, 32'd7);

    // Reset three cycles into RUN aborts without a result; then an empty run passes
    @(posedge clk); #1;
    start = 1'b1; cfg_count = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_values("midrun_reset");
    tr_clear();
    do_run(0, 1'b0, 0, 0, 0);

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      int cnt;
      bit sc_we;
      int sc_idx;
      logic [31:0] sc_a, sc_d;
      cnt = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) cfg_write(i, {$urandom_range(0, 255), 2'b00}, $urandom);
      sc_we  = ($urandom_range(0, 1) == 1);
      sc_idx = $urandom_range(0, 3);
      sc_a   = {$urandom_range(0, 255), 2'b00};
      sc_d   = $urandom;
      if (sc_we) begin
        m_addr[sc_idx] = sc_a; m_data[sc_idx] = sc_d;
      end
      tr_clear();
      for (int i = 0; i < cnt; i++) begin
        tr_idle($urandom_range(0, 2));
        if ($urandom_range(0, 4) == 0) tr_push(1'b1, $urandom | 32'h1, $urandom);
        tr_push(1'b1, m_addr[i], ($urandom_range(0, 7) == 0) ? (m_data[i] ^ 32'h1) : m_data[i]);
      end
      do_run(cnt, sc_we, sc_idx, sc_a, sc_d);
    end

    repeat (3) @(posedge clk);
    check("exp_q0_drained", 64'(exp_q0.size()), 64'd0);
    check("exp_q1_drained", 64'(exp_q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
